mem_burst_rd: RTL

Burst reader with a programmable length. It streams `len` consecutive words out of a memory block that has a one-cycle read latency onto a ready/valid interface, and marks the final word with `last`. Compared with the plain burst-out engine it adds length control, wrap-around addressing, back-pressure tolerance without a combinational `ready`→memory path, abort, and done/busy status. It sits between the Ethernet buffer RAMs and the frame-transmit datapath.

---
 rtl/mem_burst_pkg.sv | 23 ++
 rtl/mem_burst_fifo.sv | 69 ++++++
 rtl/mem_burst_rd.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mem_burst_pkg.sv
// ============================================================================
// mem_burst_pkg : shared state encoding and buffer depth for mem_burst_rd
// Revision      : 1.0
// ============================================================================
`default_nettype none

package mem_burst_pkg;

    localparam int MEM_BURST_FIFO_DEPTH = 3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_READ  = ST_READ,
        S_DRAIN = ST_DRAIN
    } state_e;

endpackage

`default_nettype wire

// File: rtl/mem_burst_fifo.sv
// ============================================================================
// mem_burst_fifo : small synchronous FIFO with flush, count and head output
// Revision       : 1.0
// ============================================================================
`default_nettype none

module mem_burst_fifo #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 3,
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              empty_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              w_do_wr;
    logic              w_do_rd;

    assign w_do_rd = rd_en_i && (count_q != '0);
    assign w_do_wr = wr_en_i && ((count_q != CNT_W'(DEPTH)) || w_do_rd);

    // Storage is cleared on reset so the head reads as zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_wr) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (w_do_rd) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;
    assign empty_o   = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/mem_burst_rd.sv
// ============================================================================
// mem_burst_rd : programmable-length burst reader from 1-cycle-latency memory
// Revision     : 1.0
// ============================================================================
`default_nettype none

module mem_burst_rd
    import mem_burst_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9,
    parameter int LEN_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] start_addr_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              abort_i,
    output logic              mem_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [DATA_W-1:0] data_out_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              last_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int CNT_W = $clog2(MEM_BURST_FIFO_DEPTH + 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  issue_cnt_q, issue_cnt_d;
    logic [LEN_W-1:0]  out_cnt_q, out_cnt_d;
    logic              done_q, done_d;
    logic              inflight_q;

    logic [CNT_W-1:0]  w_fifo_count;
    logic              w_fifo_empty;
    logic [DATA_W-1:0] w_fifo_head;
    logic [CNT_W:0]    w_occupancy;
    logic              w_issue;
    logic              w_xfer;

    // Issue is gated only by registered state, never by ready_i.
    assign w_occupancy = {1'b0, w_fifo_count} + {{CNT_W{1'b0}}, inflight_q};
    assign w_issue     = (state_q == S_READ) &&
                         (w_occupancy < (CNT_W + 1)'(MEM_BURST_FIFO_DEPTH));
    assign w_xfer      = !w_fifo_empty && ready_i;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        issue_cnt_d = issue_cnt_q;
        out_cnt_d   = out_cnt_q;
        done_d      = 1'b0;
        if (abort_i) begin
            state_d     = S_IDLE;
            issue_cnt_d = '0;
            out_cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        if (len_i != '0) begin
                            state_d     = S_READ;
                            addr_d      = start_addr_i;
                            issue_cnt_d = len_i;
                            out_cnt_d   = len_i;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (w_issue) begin
                        addr_d      = addr_q + 1'b1;
                        issue_cnt_d = issue_cnt_q - 1'b1;
                        if (issue_cnt_q == LEN_W'(1)) begin
                            state_d = S_DRAIN;
                        end
                    end
                end
                default: ;
            endcase
            if (w_xfer) begin
                out_cnt_d = out_cnt_q - 1'b1;
                if (state_q == S_DRAIN && out_cnt_q == LEN_W'(1)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            issue_cnt_q <= '0;
            out_cnt_q   <= '0;
            done_q      <= 1'b0;
            inflight_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            issue_cnt_q <= issue_cnt_d;
            out_cnt_q   <= out_cnt_d;
            done_q      <= done_d;
            // Dropping inflight on abort discards the word still in the memory pipe.
            inflight_q  <= w_issue && !abort_i;
        end
    end

    mem_burst_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (MEM_BURST_FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush_i   (abort_i),
        .wr_en_i   (inflight_q),
        .wr_data_i (mem_data_i),
        .rd_en_i   (w_xfer),
        .rd_data_o (w_fifo_head),
        .count_o   (w_fifo_count),
        .empty_o   (w_fifo_empty)
    );

    assign mem_en_o   = w_issue;
    assign mem_addr_o = addr_q;
    assign data_out_o = w_fifo_head;
    assign valid_o    = !w_fifo_empty;
    assign last_o     = !w_fifo_empty && (out_cnt_q == LEN_W'(1));
    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = done_q;

endmodule

`default_nettype wire
